universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//   Parametrised universal shift register, WIDTH bits wide, built on positive-edge D storage.
//   Supports hold, logical/arithmetic shifts, rotates, parallel load and clear.
//   Also supports an autonomous burst mode that performs N shifts without per-cycle control.
//   Sits in the flipFlops library as the general-purpose successor to the single D flip-flop.
// PARAMETERS
//   WIDTH        8    register width in bits; legal range >= 2
//   RESET_VALUE  0    value loaded into q on reset (WIDTH bits)
//   CNT_W        $clog2(WIDTH+1)  width of burst_len; localparam, derived from WIDTH
// PORTS
//   clock        in   1        single clock; all state updates on rising edge
//   reset        in   1        synchronous, active-high reset
//   enable       in   1        apply mode for one cycle (single-step, IDLE only)
//   mode         in   3        operation select (encoding below)
//   ser_in_l     in   1        serial input entering at MSB (SHR)
//   ser_in_r     in   1        serial input entering at LSB (SHL)
//   par_in       in   WIDTH    parallel load data
//   burst_start  in   1        request burst of burst_len shifts using mode
//   burst_len    in   CNT_W    number of shifts in burst, 0..WIDTH
//   q            out  WIDTH    register contents
//   qn           out  WIDTH    ~q, always complementary
//   ser_out_l    out  1        q[WIDTH-1]
//   ser_out_r    out  1        q[0]
//   busy         out  1        high while state == RUN
//   done         out  1        one-cycle pulse in state DONE
// BEHAVIOUR
//   Reset: q=RESET_VALUE, qn=~RESET_VALUE, state=IDLE, count=0, busy=0, done=0.
//     Reset has priority over all inputs, including mid-burst: the burst aborts and done never pulses.
//   Mode encoding:
//     000 HOLD
//     001 SHR   q <= {ser_in_l, q[W-1:1]}
//     010 SHL   q <= {q[W-2:0], ser_in_r}
//     011 ROR   q <= {q[0], q[W-1:1]}
//     100 ROL   q <= {q[W-2:0], q[W-1]}
//     101 ASR   q <= {q[W-1], q[W-1:1]}
//     110 LOAD  q <= par_in
//     111 CLEAR q <= 0
//   Single-step (state IDLE, burst_start=0): if enable=1, apply mode at the edge; otherwise q holds.
//     Latency is 1 cycle.
//   FSM states: IDLE, RUN, DONE.
//   IDLE, burst_start=1, mode is a shift mode (001..101):
//     accepted; mode is latched; burst_start has priority over enable.
//     burst_len>=2: shift at this edge, count<=burst_len-1, ->RUN.
//     burst_len==1: shift at this edge, ->DONE.
//     burst_len==0: no shift, ->DONE.
//   IDLE, burst_start=1, mode in {HOLD, LOAD, CLEAR}:
//     request ignored; treated as single-step (enable rules apply).
//   RUN: shift with the latched mode every edge, count<=count-1; ->DONE when count was 1.
//     enable, mode, burst_start and burst_len are all ignored.
//     Serial inputs are still sampled live each cycle.
//   DONE: q holds, done=1 for exactly one cycle; ->IDLE. burst_start is ignored in DONE.
//   Total shifts per burst = burst_len.
//     busy is high for burst_len-1 cycles; done follows the final shift by one cycle.
//   burst_len > WIDTH is legal; shifts/rotates continue (rotate by WIDTH returns the original value).
//   qn, ser_out_l and ser_out_r are combinational from q; no extra latency.
// TESTING
//   1 Reset with RESET_VALUE=8'h3C: q=3C, qn=C3, busy=0, done=0; reset while enable=1/LOAD -> q stays 3C.
//   2 LOAD A5; SHR with ser_in_l=1 -> D2; SHL with ser_in_r=0 -> A4; HOLD -> A4 unchanged.
//   3 LOAD 81: ROR -> C0; ROL -> 81; eight ROLs -> 81; LOAD 80, ASR -> C0; CLEAR -> 00.
//   4 Burst: q=01, ROL, len=3, start
//       -> q=02,04,08 on consecutive edges; busy=1 for 2 cycles; done pulses once; q holds 08.
//   5 Burst of len=8 SHL; reset after 3 shifts -> q=RESET_VALUE, busy=0, done never asserts.
//   6 Burst edge cases:
//       len=0 -> q unchanged, done pulses next cycle.
//       start with LOAD mode -> no burst, q=par_in if enable=1.
//       start during RUN -> ignored.

Source files
------------

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, logical/arithmetic shifts, rotates, parallel load and clear,
// plus an autonomous burst engine that repeats one shift mode burst_len times.
module universal_shift_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    localparam int              CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic [WIDTH-1:0] par_in,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_ROR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ASR   = 3'b101;
    localparam logic [2:0] MODE_LOAD  = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic [2:0]       mode_r,  mode_s;
    logic [WIDTH-1:0] q_r,     q_s;

    // Next register value for one application of an operation
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [WIDTH-1:0] cur,
        input logic [2:0]       op,
        input logic             sil,
        input logic             sir,
        input logic [WIDTH-1:0] par
    );
        case (op)
            MODE_HOLD:  apply_op = cur;
            MODE_SHR:   apply_op = {sil, cur[WIDTH-1:1]};
            MODE_SHL:   apply_op = {cur[WIDTH-2:0], sir};
            MODE_ROR:   apply_op = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:   apply_op = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ASR:   apply_op = {cur[WIDTH-1], cur[WIDTH-1:1]};
            MODE_LOAD:  apply_op = par;
            MODE_CLEAR: apply_op = {WIDTH{1'b0}};
            default:    apply_op = cur;
        endcase
    endfunction

    // Only the five shift/rotate modes may start a burst
    function automatic logic is_shift_mode(input logic [2:0] op);
        is_shift_mode = (op >= MODE_SHR) && (op <= MODE_ASR);
    endfunction

    // Next-state, counter, latched mode and data path
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        mode_s  = mode_r;
        q_s     = q_r;
        case (state_r)
            ST_IDLE: begin
                if (burst_start && is_shift_mode(mode)) begin
                    mode_s = mode;
                    if (burst_len == CNT_ZERO) begin
                        state_s = ST_DONE;
                    end else if (burst_len == CNT_ONE) begin
                        q_s     = apply_op(q_r, mode, ser_in_l, ser_in_r, par_in);
                        state_s = ST_DONE;
                    end else begin
                        q_s     = apply_op(q_r, mode, ser_in_l, ser_in_r, par_in);
                        count_s = burst_len - CNT_ONE;
                        state_s = ST_RUN;
                    end
                end else if (enable) begin
                    q_s = apply_op(q_r, mode, ser_in_l, ser_in_r, par_in);
                end else begin
                    q_s = q_r;
                end
            end
            ST_RUN: begin
                // Serial inputs stay live; only the operation itself is latched
                q_s     = apply_op(q_r, mode_r, ser_in_l, ser_in_r, par_in);
                count_s = count_r - CNT_ONE;
                if (count_r == CNT_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                count_s = CNT_ZERO;
            end
        endcase
    end

    // State and data registers; reset wins over everything, aborting any burst
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= CNT_ZERO;
            mode_r  <= MODE_HOLD;
            q_r     <= RESET_VALUE;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            mode_r  <= mode_s;
            q_r     <= q_s;
        end
    end

    assign q         = q_r;
    assign qn        = ~q_r;
    assign ser_out_l = q_r[WIDTH-1];
    assign ser_out_r = q_r[0];
    assign busy      = (state_r == ST_RUN);
    assign done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH=8, RESET_VALUE=8'h3C).
module tb_universal_shift_register;

    localparam logic [2:0] HOLD = 3'b000, SHR = 3'b001, SHL = 3'b010, ROR = 3'b011;
    localparam logic [2:0] ROL = 3'b100, ASR = 3'b101, LOAD = 3'b110, CLR = 3'b111;

    logic       clock = 1'b0;
    logic       reset, enable, ser_in_l, ser_in_r, burst_start;
    logic [2:0] mode;
    logic [7:0] par_in;
    logic [3:0] burst_len;
    logic [7:0] q, qn;
    logic       ser_out_l, ser_out_r, busy, done;

    int total = 0;
    int bad   = 0;

    universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode),
        .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .par_in(par_in),
        .burst_start(burst_start), .burst_len(burst_len),
        .q(q), .qn(qn), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic single(input logic [2:0] m, input logic [7:0] p);
        enable = 1'b1; mode = m; par_in = p; burst_start = 1'b0;
        step();
        enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; mode = LOAD; par_in = 8'hFF;
        ser_in_l = 1'b0; ser_in_r = 1'b0; burst_start = 1'b0; burst_len = 4'd0;
        step(); step();
        total++; if (q !== 8'h3C) begin $display("FAIL reset_q got=%h exp=3c", q); bad++; end
        total++; if (qn !== 8'hC3) begin $display("FAIL reset_qn got=%h exp=c3", qn); bad++; end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done); bad++; end
        total++; if (ser_out_l !== 1'b0 || ser_out_r !== 1'b0) begin $display("FAIL reset_serout l=%b r=%b exp=0/0", ser_out_l, ser_out_r); bad++; end
        reset = 1'b0; enable = 1'b0;
    endtask

    task automatic test_shift();
        single(LOAD, 8'hA5);
        total++; if (q !== 8'hA5) begin $display("FAIL load_a5 got=%h exp=a5", q); bad++; end
        ser_in_l = 1'b1;
        single(SHR, 8'h00);
        total++; if (q !== 8'hD2) begin $display("FAIL shr got=%h exp=d2", q); bad++; end
        ser_in_r = 1'b0;
        single(SHL, 8'h00);
        total++; if (q !== 8'hA4) begin $display("FAIL shl got=%h exp=a4", q); bad++; end
        single(HOLD, 8'h00);
        total++; if (q !== 8'hA4) begin $display("FAIL hold got=%h exp=a4", q); bad++; end
        mode = SHR; enable = 1'b0;
        step();
        total++; if (q !== 8'hA4) begin $display("FAIL no_enable got=%h exp=a4", q); bad++; end
    endtask

    task automatic test_rotate();
        single(LOAD, 8'h81);
        single(ROR, 8'h00);
        total++; if (q !== 8'hC0 || ser_out_l !== 1'b1 || ser_out_r !== 1'b0) begin $display("FAIL ror got=%h exp=c0", q); bad++; end
        single(ROL, 8'h00);
        total++; if (q !== 8'h81) begin $display("FAIL rol got=%h exp=81", q); bad++; end
        single(ROL, 8'h00);
        total++; if (q !== 8'h03) begin $display("FAIL rol1 got=%h exp=03", q); bad++; end
        for (int i = 0; i < 7; i++) single(ROL, 8'h00);
        total++; if (q !== 8'h81) begin $display("FAIL rol8 got=%h exp=81", q); bad++; end
        single(LOAD, 8'h80);
        single(ASR, 8'h00);
        total++; if (q !== 8'hC0 || qn !== 8'h3F) begin $display("FAIL asr got=%h qn=%h exp=c0/3f", q, qn); bad++; end
        single(CLR, 8'h00);
        total++; if (q !== 8'h00) begin $display("FAIL clear got=%h exp=00", q); bad++; end
    endtask

    task automatic test_burst();
        logic [7:0] exp_q [3] = '{8'h02, 8'h04, 8'h08};
        int busy_cnt = 0;
        int done_cnt = 0;
        single(LOAD, 8'h01);
        mode = ROL; burst_len = 4'd3; burst_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            burst_start = 1'b0; mode = CLR; enable = 1'b1;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            total++; if (q !== exp_q[i]) begin $display("FAIL burst_q%0d got=%h exp=%h", i, q, exp_q[i]); bad++; end
        end
        total++; if (done !== 1'b1) begin $display("FAIL burst_done got=%b exp=1", done); bad++; end
        enable = 1'b0;
        step();
        if (done === 1'b1) done_cnt++;
        total++; if (busy_cnt != 2) begin $display("FAIL burst_busy_cycles got=%0d exp=2", busy_cnt); bad++; end
        total++; if (done_cnt != 1) begin $display("FAIL burst_done_pulses got=%0d exp=1", done_cnt); bad++; end
        total++; if (q !== 8'h08 || busy !== 1'b0) begin $display("FAIL burst_hold got=%h busy=%b exp=08/0", q, busy); bad++; end
    endtask

    task automatic test_burst_reset();
        int done_cnt = 0;
        single(LOAD, 8'h01);
        ser_in_r = 1'b0; mode = SHL; burst_len = 4'd8; burst_start = 1'b1;
        step();
        burst_start = 1'b0;
        step(); step();
        total++; if (q !== 8'h08 || busy !== 1'b1) begin $display("FAIL abort_pre got=%h busy=%b exp=08/1", q, busy); bad++; end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (q !== 8'h3C || busy !== 1'b0) begin $display("FAIL abort_reset got=%h busy=%b exp=3c/0", q, busy); bad++; end
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) done_cnt++;
            step();
        end
        total++; if (done_cnt != 0 || q !== 8'h3C) begin $display("FAIL abort_no_done pulses=%0d q=%h exp=0/3c", done_cnt, q); bad++; end
    endtask

    task automatic test_edge_cases();
        int busy_cnt = 0;
        int guard = 0;
        // zero-length burst
        mode = ROR; burst_len = 4'd0; burst_start = 1'b1;
        step();
        burst_start = 1'b0;
        total++; if (q !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin $display("FAIL len0 got=%h done=%b busy=%b exp=3c/1/0", q, done, busy); bad++; end
        step();
        total++; if (done !== 1'b0) begin $display("FAIL len0_done_once got=%b exp=0", done); bad++; end
        // start with a non-shift mode behaves as single-step
        mode = LOAD; par_in = 8'h5A; burst_len = 4'd3; burst_start = 1'b1; enable = 1'b1;
        step();
        total++; if (q !== 8'h5A || busy !== 1'b0) begin $display("FAIL load_start got=%h busy=%b exp=5a/0", q, busy); bad++; end
        enable = 1'b0; par_in = 8'h11;
        step();
        total++; if (q !== 8'h5A || done !== 1'b0) begin $display("FAIL load_start_noen got=%h done=%b exp=5a/0", q, done); bad++; end
        // start held high through RUN and DONE is ignored
        mode = ROL; burst_len = 4'd3;
        step();
        mode = ROR; burst_len = 4'd1; enable = 1'b1;
        total++; if (q !== 8'hB4 || busy !== 1'b1) begin $display("FAIL run_start0 got=%h exp=b4", q); bad++; end
        step();
        total++; if (q !== 8'h69) begin $display("FAIL run_start1 got=%h exp=69", q); bad++; end
        step();
        total++; if (q !== 8'hD2 || done !== 1'b1) begin $display("FAIL run_start2 got=%h done=%b exp=d2/1", q, done); bad++; end
        step();
        burst_start = 1'b0; enable = 1'b0;
        total++; if (q !== 8'hD2 || done !== 1'b0 || busy !== 1'b0) begin $display("FAIL done_ignores_start got=%h done=%b busy=%b exp=d2/0/0", q, done, busy); bad++; end
        // burst length equal to WIDTH rotates back to the start value
        mode = ROR; burst_len = 4'd8; burst_start = 1'b1;
        step();
        burst_start = 1'b0;
        while (done !== 1'b1 && guard < 20) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            guard++;
        end
        total++; if (done !== 1'b1) begin $display("FAIL len8_timeout done=%b exp=1", done); bad++; end
        total++; if (q !== 8'hD2 || busy_cnt != 7) begin $display("FAIL len8 got=%h busy_cycles=%0d exp=d2/7", q, busy_cnt); bad++; end
        step();
    endtask

    initial begin
        test_reset();
        test_shift();
        test_rotate();
        test_burst();
        test_burst_reset();
        test_edge_cases();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
